// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, inverse key schedule on the fly.
// Latency: 10 clock edges from accepted start to the done pulse; pt holds until the next completion.
// Backpressure: none; start is ignored while busy=1, with no queuing and no error indication.
module aes128_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct,
  input  logic [127:0] key_last,
  output logic         busy,
  output logic         done,
  output logic [127:0] pt
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX_TBL << {x, 3'b000};
    return t[2047:2040];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = INV_SBOX_TBL << {x, 3'b000};
    return t[2047:2040];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r + 4c) of the state lives at bits [127-8(r+4c) -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // One column times the {0e,0b,0d,09} circulant matrix.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Undo one forward key-expansion step: round-r key -> round-(r-1) key.
  function automatic logic [127:0] inv_key(input logic [127:0] rk, input logic [3:0] r);
    logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3, rot;
    a0  = rk[127:96];
    a1  = rk[95:64];
    a2  = rk[63:32];
    a3  = rk[31:0];
    b3  = a3 ^ a2;
    b2  = a2 ^ a1;
    b1  = a1 ^ a0;
    rot = {b3[23:0], b3[31:24]};
    b0  = a0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
             ^ {rcon(r), 24'h0};
    return {b0, b1, b2, b3};
  endfunction

  state_e       st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;

  logic [127:0] rk_next;
  logic [127:0] ark_out;

  // Round datapath and key step evaluated side by side from the current registers.
  always_comb begin
    rk_next = inv_key(rk_q, rnd_q);
    ark_out = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_next;
  end

  // Next-state logic: accept in idle, iterate rounds, finish without InvMixColumns.
  always_comb begin
    st_d   = st_q;
    rnd_d  = rnd_q;
    blk_d  = blk_q;
    rk_d   = rk_q;
    pt_d   = pt_q;
    done_d = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          blk_d = ct ^ key_last;
          rk_d  = key_last;
          rnd_d = 4'd10;
          st_d  = S_RUN;
        end
      end
      S_RUN: begin
        rk_d = rk_next;
        if (rnd_q == 4'd1) begin
          pt_d   = ark_out;
          done_d = 1'b1;
          rnd_d  = 4'd0;
          st_d   = S_IDLE;
        end else begin
          blk_d = inv_mix_columns(ark_out);
          rnd_d = rnd_q - 4'd1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      rnd_q  <= 4'd0;
      blk_q  <= '0;
      rk_q   <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      blk_q  <= blk_d;
      rk_q   <= rk_d;
      pt_q   <= pt_d;
      done_q <= done_d;
    end
  end

  assign busy = (st_q == S_RUN);
  assign done = done_q;
  assign pt   = pt_q;

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Directed-vector bench for aes128_dec_iter using FIPS-197 known answers.
// Latency: checks done exactly 10 edges after accept.
// Backpressure: exercises start-while-busy rejection and back-to-back starts.
module tb_aes128_dec_iter;

  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ct;
  logic [127:0] key_last;
  logic         busy;
  logic         done;
  logic [127:0] pt;

  int n_chk  = 0;
  int n_pass = 0;

  aes128_dec_iter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ct       (ct),
    .key_last (key_last),
    .busy     (busy),
    .done     (done),
    .pt       (pt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a vector at E0, scramble inputs afterwards, check E1..E10.
  task automatic run_vec(input string tag, input logic [127:0] c, input logic [127:0] k,
                         input logic [127:0] exp_pt, input logic [127:0] prev_pt);
    start    = 1'b1;
    ct       = c;
    key_last = k;
    tick();
    start    = 1'b0;
    ct       = {$urandom, $urandom, $urandom, $urandom};
    key_last = {$urandom, $urandom, $urandom, $urandom};
    for (int e = 1; e <= 9; e++) begin
      chk({tag, "_busy_mid"}, {127'd0, busy}, 128'd1);
      chk({tag, "_done_mid"}, {127'd0, done}, 128'd0);
      chk({tag, "_pt_hold"}, pt, prev_pt);
      tick();
    end
    chk({tag, "_busy_mid"}, {127'd0, busy}, 128'd1);
    tick();
    chk({tag, "_done_e10"}, {127'd0, done}, 128'd1);
    chk({tag, "_busy_e10"}, {127'd0, busy}, 128'd0);
    chk({tag, "_pt"}, pt, exp_pt);
  endtask

  // Count done pulses over a fixed window.
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) n++;
    end
  endtask

  initial begin
    int nd;
    rst      = 1'b1;
    start    = 1'b1;
    ct       = C1_CT;
    key_last = C1_KEY;
    tick();
    tick();
    // rst has priority over start
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_pt", pt, 128'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_busy", {127'd0, busy}, 128'd0);

    // FIPS-197 C.1
    run_vec("c1", C1_CT, C1_KEY, C1_PT, 128'd0);
    tick();
    chk("c1_done_drop", {127'd0, done}, 128'd0);
    chk("c1_pt_keep", pt, C1_PT);

    // FIPS-197 App B, plus the recovered cipher key
    run_vec("b", B_CT, B_KEY, B_PT, C1_PT);
    chk("b_rk0", dut.rk_q, B_RK0);
    tick();
    chk("b_done_drop", {127'd0, done}, 128'd0);

    // Start while busy is ignored
    start    = 1'b1;
    ct       = C1_CT;
    key_last = C1_KEY;
    tick();
    start    = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    start    = 1'b1;
    ct       = B_CT;
    key_last = B_KEY;
    tick();
    start    = 1'b0;
    for (int e = 5; e <= 9; e++) begin
      chk("rej_done_mid", {127'd0, done}, 128'd0);
      tick();
    end
    tick();
    chk("rej_done_e10", {127'd0, done}, 128'd1);
    chk("rej_pt", pt, C1_PT);
    count_done(14, nd);
    chk("rej_no_second_done", nd, 128'd0);
    chk("rej_pt_keep", pt, C1_PT);

    // Back-to-back: second start on the done cycle
    run_vec("b2b1", C1_CT, C1_KEY, C1_PT, C1_PT);
    run_vec("b2b2", B_CT, B_KEY, B_PT, C1_PT);
    tick();

    // Reset mid-operation
    start    = 1'b1;
    ct       = C1_CT;
    key_last = C1_KEY;
    tick();
    start    = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);
    chk("abort_pt", pt, 128'd0);
    count_done(14, nd);
    chk("abort_no_done", nd, 128'd0);
    chk("abort_pt_keep", pt, 128'd0);
    run_vec("fresh", C1_CT, C1_KEY, C1_PT, 128'd0);
    tick();
    chk("fresh_done_drop", {127'd0, done}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
